// File: rtl/matrix_dsp_batch_core.sv
// Bus-mapped batch front end for an external MatrixDSP engine: matrix register file,
// input/output vector FIFOs and a sequencer that drives the engine's cycle/ready handshake.
//
// state   | meaning
// S_IDLE  | no batch running
// S_ISSUE | head vector waiting for output FIFO space, then eng_cycle pulse
// S_WAIT  | engine busy; eng_ready moves the head result into the output FIFO
module matrix_dsp_batch_core #(
    parameter int LANES = 3,
    parameter int ROWS  = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               address,
    input  logic                     read,
    input  logic                     write,
    input  logic [31:0]              writeData,
    output logic [31:0]              readData,
    output logic                     waitrequest,
    output logic                     irq,
    output logic                     eng_cycle,
    input  logic                     eng_ready,
    output logic [LANES*32-1:0]      eng_vector,
    output logic [ROWS*LANES*32-1:0] eng_matrix,
    input  logic [LANES*32-1:0]      eng_result
);
    localparam int NM = ROWS * LANES;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int MW = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    state_t state, state_nxt;

    logic [5:0]          idx;
    logic [MW-1:0]       mat_idx;
    logic                sel_ctrl, sel_stat, sel_push, sel_pop, sel_mat;
    logic                ctrl_blocking, ctrl_irq_en;
    logic                done, ovf, unf, blk_pend, busy;
    logic                start_req, launch, clr, wr_acc, rd_acc, blk_stall, pop_stall;
    logic                push_word, commit, commit_ok, pop_word, pop_free, unf_set, w1c;
    logic                seq_pop, seq_push, seq_push_ok, done_set;
    logic                in_full, out_full, out_empty;
    logic [31:0]         mat [NM];
    logic [LANES*32-1:0] in_mem [DEPTH];
    logic [LANES*32-1:0] out_mem [DEPTH];
    logic [31:0]         in_acc [LANES];
    logic [31:0]         out_lanes [LANES];
    logic [LANES*32-1:0] commit_vec, out_head;
    logic [PW-1:0]       in_wr, in_rd, out_wr, out_rd;
    logic [CW-1:0]       in_count, out_count;
    logic [4:0]          in_c5, out_c5;
    logic [LW-1:0]       in_lane, out_lane;
    logic [31:0]         status;
    logic                unused_bits;

    assign idx      = address[7:2];
    assign mat_idx  = MW'(idx - 6'd16);
    assign sel_ctrl = (idx == 6'd0);
    assign sel_stat = (idx == 6'd1);
    assign sel_push = (idx == 6'd2);
    assign sel_pop  = (idx == 6'd3);
    assign sel_mat  = (idx >= 6'd16) && ({1'b0, idx} < 7'(16 + NM));

    assign in_full   = (in_count == FULL_CNT);
    assign out_full  = (out_count == FULL_CNT);
    assign out_empty = (out_count == '0);
    assign busy      = (state != S_IDLE);

    // A blocking start launches on its first strobe cycle and completes once done is seen.
    assign start_req   = write && sel_ctrl && writeData[0] && !writeData[3];
    assign blk_stall   = start_req && ctrl_blocking && !(blk_pend && done);
    assign pop_stall   = read && sel_pop && out_empty && busy && ctrl_blocking;
    assign waitrequest = !reset && (blk_stall || pop_stall);
    assign wr_acc      = write && !waitrequest;
    assign rd_acc      = read && !waitrequest;
    assign launch      = start_req && !blk_pend;
    assign clr         = wr_acc && sel_ctrl && writeData[3];
    assign w1c         = wr_acc && sel_stat;

    assign push_word   = wr_acc && sel_push;
    assign commit      = push_word && (in_lane == LAST_LANE);
    assign commit_ok   = commit && !in_full;
    assign pop_word    = rd_acc && sel_pop && !out_empty;
    assign pop_free    = pop_word && (out_lane == LAST_LANE);
    assign unf_set     = rd_acc && sel_pop && out_empty;
    assign seq_push_ok = seq_push && !out_full;

    assign irq        = done && ctrl_irq_en;
    assign eng_vector = in_mem[in_rd];
    assign out_head   = out_mem[out_rd];
    assign in_c5      = 5'(in_count);
    assign out_c5     = 5'(out_count);
    assign status     = {12'd0, out_c5[3:0], 4'd0, in_c5[3:0], 2'd0,
                         unf, ovf, out_empty, in_full, done, busy};
    assign unused_bits = ^{address[1:0], in_c5[4], out_c5[4]};

    always_comb begin
        commit_vec = '0;
        for (int l = 0; l < LANES; l++) begin
            commit_vec[(LANES-1-l)*32 +: 32] = (l == LANES - 1) ? writeData : in_acc[l];
            out_lanes[l] = out_head[(LANES-1-l)*32 +: 32];
        end
    end

    always_comb begin
        eng_matrix = '0;
        for (int e = 0; e < NM; e++) begin
            eng_matrix[(NM-1-e)*32 +: 32] = mat[e];
        end
    end

    always_comb begin
        readData = '0;
        if (read) begin
            if (sel_ctrl)                   readData = {29'd0, ctrl_irq_en, ctrl_blocking, 1'b0};
            else if (sel_stat)              readData = status;
            else if (sel_pop && !out_empty) readData = out_lanes[out_lane];
            else if (sel_mat)               readData = mat[mat_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (push_word)   in_acc[in_lane]  <= writeData;
        if (commit_ok)   in_mem[in_wr]    <= commit_vec;
        if (seq_push_ok) out_mem[out_wr]  <= eng_result;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_blocking <= 1'b0;
            ctrl_irq_en   <= 1'b0;
            for (int e = 0; e < NM; e++) mat[e] <= '0;
        end else begin
            if (wr_acc && sel_ctrl) begin
                ctrl_blocking <= writeData[1];
                ctrl_irq_en   <= writeData[2];
            end
            if (wr_acc && sel_mat) mat[mat_idx] <= writeData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            in_wr     <= '0;
            in_rd     <= '0;
            in_count  <= '0;
            in_lane   <= '0;
            out_wr    <= '0;
            out_rd    <= '0;
            out_count <= '0;
            out_lane  <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            done      <= 1'b0;
            blk_pend  <= 1'b0;
        end else begin
            if (push_word)   in_lane <= commit ? '0 : in_lane + LW'(1);
            if (commit_ok)   in_wr   <= in_wr + PW'(1);
            if (seq_pop)     in_rd   <= in_rd + PW'(1);
            in_count <= in_count + CW'(commit_ok) - CW'(seq_pop);
            if (seq_push_ok) out_wr  <= out_wr + PW'(1);
            if (pop_free)    out_rd  <= out_rd + PW'(1);
            if (pop_word)    out_lane <= pop_free ? '0 : out_lane + LW'(1);
            out_count <= out_count + CW'(seq_push_ok) - CW'(pop_free);

            if (commit && in_full)        ovf <= 1'b1;
            else if (w1c && writeData[4]) ovf <= 1'b0;
            if (unf_set)                  unf <= 1'b1;
            else if (w1c && writeData[5]) unf <= 1'b0;
            if (done_set)                                done <= 1'b1;
            else if (launch || (w1c && writeData[1]))    done <= 1'b0;

            if (launch && ctrl_blocking)       blk_pend <= 1'b1;
            else if (!start_req || !waitrequest) blk_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) state <= S_IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        eng_cycle = 1'b0;
        seq_pop   = 1'b0;
        seq_push  = 1'b0;
        done_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (launch) begin
                    if (in_count != '0) state_nxt = S_ISSUE;
                    else                done_set  = 1'b1;
                end
            end
            S_ISSUE: begin
                if (!out_full && !clr && !reset) begin
                    eng_cycle = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (eng_ready) begin
                    seq_pop  = 1'b1;
                    seq_push = 1'b1;
                    // vectors committed during the batch join it
                    if (in_count > CW'(1) || commit_ok) begin
                        state_nxt = S_ISSUE;
                    end else begin
                        state_nxt = S_IDLE;
                        done_set  = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule
